axis_tx_rr_arbiter: RTL and testbench
=====================================

Name: axis_tx_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one egress AXI-Stream port between NUM_MASTERS tenant tx streams.
- Sits upstream of the per-port egress protocol verifier: each tenant's verified stream enters here, and the single arbitrated stream goes to the network interface.
- Grant is held from the first beat to the tlast beat, so packets never interleave.
- Per-tenant enable mask supports decoupling; a mid-packet stall watchdog flags hung tenants.

Parameters:
- NUM_MASTERS, 4, number of requesting streams (2..16).
- AXIS_BUS_WIDTH, 64, tdata width in bits (multiple of 8).
- AXIS_ID_WIDTH, 4, tid width (0 allowed; port then 1 bit, tied 0).
- AXIS_DEST_WIDTH, 4, tdest width (0 allowed; port then 1 bit, tied 0).
- STALL_TIMEOUT_CYCLES, 255, consecutive mid-packet tvalid-low cycles before stall error.

Ports:
- aclk  in  1  clock, all interfaces synchronous.
- aresetn  in  1  asynchronous active-low reset.
- axis_in_tdata  in  NUM_MASTERS*AXIS_BUS_WIDTH  tenant tdata, master i at slice i.
- axis_in_tid  in  NUM_MASTERS*max(1,AXIS_ID_WIDTH)  tenant tid.
- axis_in_tdest  in  NUM_MASTERS*max(1,AXIS_DEST_WIDTH)  tenant tdest.
- axis_in_tkeep  in  NUM_MASTERS*AXIS_BUS_WIDTH/8  tenant tkeep.
- axis_in_tlast  in  NUM_MASTERS  tenant tlast.
- axis_in_tvalid  in  NUM_MASTERS  tenant tvalid.
- axis_in_tready  out  NUM_MASTERS  tenant tready.
- axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out  matching single widths  arbitrated stream.
- axis_out_tready  in  1  downstream ready.
- axis_out_tsrc  out  clog2(NUM_MASTERS)  index of the master owning the current output beat.
- master_enable  in  NUM_MASTERS  1 = master may win arbitration.
- stall_error_irq  out  1  sticky stall indication.
- stall_error_src  out  clog2(NUM_MASTERS)  master that caused the first stall.
- stall_error_clear  in  1  one-cycle pulse clears stall error.

Behaviour:
- Reset (async assert, sync release): state IDLE, last_grant = NUM_MASTERS-1, axis_out_tvalid 0, axis_in_tready all 0, stall_error_irq 0, stall_error_src 0, axis_out_tsrc 0, stall counter 0. Reset mid-packet discards the partial packet; no recovery beat is issued.
- FSM IDLE:
  - req = axis_in_tvalid & master_enable.
  - Pick the first set req bit searching from last_grant+1 upward with wrap.
  - If any bit is set: register grant = pick and go to BUSY next cycle. Otherwise stay in IDLE.
  - All axis_in_tready are 0 in IDLE.
- FSM BUSY:
  - axis_in_tready[grant] = slice_ready, where slice_ready = axis_out_tready | ~axis_out_tvalid. All other tready bits are 0.
  - An accepted granted beat loads the output register slice (data, tid, tdest, tkeep, tlast, tsrc = grant) with axis_out_tvalid = 1.
  - If axis_out_tready=1 and no new beat is loaded, axis_out_tvalid clears.
  - When an accepted beat has tlast=1: last_grant <= grant and state goes to IDLE.
- Latency and throughput:
  - Input-to-output latency is 1 cycle.
  - Full throughput within a packet.
  - Exactly 1 idle cycle (IDLE arbitration) between consecutive packets.
- Enable handling:
  - master_enable is consulted only in IDLE.
  - Deasserting it mid-packet does not abort; the packet completes.
- Stall watchdog:
  - Counter increments in BUSY while axis_in_tvalid[grant]=0.
  - It resets on any granted tvalid=1, and in IDLE.
  - It saturates at STALL_TIMEOUT_CYCLES.
  - Reaching the limit sets stall_error_irq and latches stall_error_src = grant, but only if the irq is not already set.
  - Grant is held; framing is preserved.
  - If a set and stall_error_clear occur in the same cycle, set wins.
- The zero-width tid/tdest ports output 0.

Decomposition:
- Package axis_arb_pkg holds:
  - the arb_state_t enum {IDLE, BUSY};
  - the localparam helper function idx_width(n) = max(1, clog2(n));
  - the function sel_w(w) = max(1, w).
- One sub-module, axis_rr_picker: combinational. Inputs are the req vector and last_grant; outputs are any_req and pick. It contains the rotate-and-priority-encode logic.

Test Plan:
- NUM_MASTERS=4, masters 0 and 2 each send a 3-beat packet, all enabled, out_tready=1 -> output is packet0 (tsrc=0), one idle cycle, then packet2 (tsrc=2); 7 cycles from first grant to last beat.
- All 4 masters hold continuous 1-beat packets -> tsrc sequence 0,1,2,3,0,... with no master skipped.
- Master 1 sends 4 beats while out_tready toggles 1,0,1,0 -> no beat lost or duplicated; tdata order preserved; axis_out tvalid stable while tready=0.
- Master 3 deasserts tvalid after beat 2 for 255 cycles, STALL_TIMEOUT_CYCLES=255 -> stall_error_irq=1 and stall_error_src=3. Other masters stay blocked until master 3's tlast. A clear pulse drops the irq.
- master_enable[0]=0 with master 0 valid; master_enable deasserted mid-packet for master 1 -> master 0 never granted; master 1's packet completes, then master 1 is not regranted.
- aresetn asserted in the middle of a BUSY packet -> axis_out_tvalid=0 and all tready=0 immediately. After release, arbitration restarts from master 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the AXI-Stream tx round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned sel_w(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Round-robin pick: first requesting index after last_grant, wrapping around.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  localparam int unsigned IW          = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last_grant,
  output logic                   any_req,
  output logic [IW-1:0]          pick
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    any_req = |req;
    pick    = '0;
    cand    = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_MASTERS);
      if (req[cand]) pick = cand;
    end
  end

endmodule

// File: rtl/axis_tx_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream egress port, with
// per-tenant enable and a mid-packet stall watchdog.
module axis_tx_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS          = 4,
  parameter  int unsigned AXIS_BUS_WIDTH       = 64,
  parameter  int unsigned AXIS_ID_WIDTH        = 4,
  parameter  int unsigned AXIS_DEST_WIDTH      = 4,
  parameter  int unsigned STALL_TIMEOUT_CYCLES = 255,
  localparam int unsigned IW                   = idx_width(NUM_MASTERS),
  localparam int unsigned TIW                  = sel_w(AXIS_ID_WIDTH),
  localparam int unsigned TDW                  = sel_w(AXIS_DEST_WIDTH),
  localparam int unsigned KW                   = AXIS_BUS_WIDTH / 8
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NUM_MASTERS*AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [NUM_MASTERS*TIW-1:0]          axis_in_tid,
  input  logic [NUM_MASTERS*TDW-1:0]          axis_in_tdest,
  input  logic [NUM_MASTERS*KW-1:0]           axis_in_tkeep,
  input  logic [NUM_MASTERS-1:0]              axis_in_tlast,
  input  logic [NUM_MASTERS-1:0]              axis_in_tvalid,
  output logic [NUM_MASTERS-1:0]              axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]           axis_out_tdata,
  output logic [TIW-1:0]                      axis_out_tid,
  output logic [TDW-1:0]                      axis_out_tdest,
  output logic [KW-1:0]                       axis_out_tkeep,
  output logic                                axis_out_tlast,
  output logic                                axis_out_tvalid,
  input  logic                                axis_out_tready,
  output logic [IW-1:0]                       axis_out_tsrc,
  input  logic [NUM_MASTERS-1:0]              master_enable,
  output logic                                stall_error_irq,
  output logic [IW-1:0]                       stall_error_src,
  input  logic                                stall_error_clear
);

  localparam int unsigned CW = $clog2(STALL_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STALL_LIMIT = CW'(STALL_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] STALL_PRE   = CW'(STALL_TIMEOUT_CYCLES - 1);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d, last_grant_q, last_grant_d;
  logic [AXIS_BUS_WIDTH-1:0] tdata_q, tdata_d;
  logic [TIW-1:0]      tid_q, tid_d;
  logic [TDW-1:0]      tdest_q, tdest_d;
  logic [KW-1:0]       tkeep_q, tkeep_d;
  logic                tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic [IW-1:0]       tsrc_q, tsrc_d;
  logic [CW-1:0]       stall_cnt_q, stall_cnt_d;
  logic                irq_q, irq_d;
  logic [IW-1:0]       err_src_q, err_src_d;

  logic                any_req;
  logic [IW-1:0]       pick;
  logic [AXIS_BUS_WIDTH-1:0] sel_tdata;
  logic [TIW-1:0]      sel_tid;
  logic [TDW-1:0]      sel_tdest;
  logic [KW-1:0]       sel_tkeep;
  logic                sel_tlast, sel_tvalid;
  logic                slice_ready, accept, stall_hit;

  axis_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req        (axis_in_tvalid & master_enable),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .pick       (pick)
  );

  // Granted-master input mux and handshake.
  always_comb begin
    sel_tdata      = '0;
    sel_tid        = '0;
    sel_tdest      = '0;
    sel_tkeep      = '0;
    sel_tlast      = 1'b0;
    sel_tvalid     = 1'b0;
    axis_in_tready = '0;
    slice_ready    = axis_out_tready | ~tvalid_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == IW'(i)) begin
        sel_tdata  = axis_in_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        sel_tid    = axis_in_tid[i*TIW +: TIW];
        sel_tdest  = axis_in_tdest[i*TDW +: TDW];
        sel_tkeep  = axis_in_tkeep[i*KW +: KW];
        sel_tlast  = axis_in_tlast[i];
        sel_tvalid = axis_in_tvalid[i];
        axis_in_tready[i] = (state_q == BUSY) & slice_ready;
      end
    end
    accept    = (state_q == BUSY) & sel_tvalid & slice_ready;
    stall_hit = (state_q == BUSY) & ~sel_tvalid & (stall_cnt_q == STALL_PRE);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tdata_d      = tdata_q;
    tid_d        = tid_q;
    tdest_d      = tdest_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q & ~axis_out_tready;
    tsrc_d       = tsrc_q;
    stall_cnt_d  = stall_cnt_q;
    irq_d        = irq_q;
    err_src_d    = err_src_q;
    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (any_req) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          tdata_d  = sel_tdata;
          tid_d    = (AXIS_ID_WIDTH == 0) ? '0 : sel_tid;
          tdest_d  = (AXIS_DEST_WIDTH == 0) ? '0 : sel_tdest;
          tkeep_d  = sel_tkeep;
          tlast_d  = sel_tlast;
          tsrc_d   = grant_q;
          tvalid_d = 1'b1;
          if (sel_tlast) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
        if (sel_tvalid) stall_cnt_d = '0;
        else if (stall_cnt_q != STALL_LIMIT) stall_cnt_d = stall_cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // A new stall outranks a simultaneous clear.
    if (stall_error_clear) irq_d = 1'b0;
    if (stall_hit && !irq_q) begin
      irq_d     = 1'b1;
      err_src_d = grant_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_MASTERS - 1);
      tdata_q      <= '0;
      tid_q        <= '0;
      tdest_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      tsrc_q       <= '0;
      stall_cnt_q  <= '0;
      irq_q        <= 1'b0;
      err_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tdata_q      <= tdata_d;
      tid_q        <= tid_d;
      tdest_q      <= tdest_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      tsrc_q       <= tsrc_d;
      stall_cnt_q  <= stall_cnt_d;
      irq_q        <= irq_d;
      err_src_q    <= err_src_d;
    end
  end

  assign axis_out_tdata  = tdata_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = tdest_q;
  assign axis_out_tkeep  = tkeep_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tsrc   = tsrc_q;
  assign stall_error_irq = irq_q;
  assign stall_error_src = err_src_q;

endmodule

// File: tb/tb_axis_tx_rr_arbiter.sv
// Self-checking bench for axis_tx_rr_arbiter: per-master beat queues feed the
// DUT, and a packet-level round-robin model predicts the egress sequence.
module tb_axis_tx_rr_arbiter;

  localparam int NM    = 4;
  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int LIMIT = 255;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  tid;
    logic [3:0]  dest;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  src;
  } beat_t;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NM*DW-1:0]  axis_in_tdata = '0;
  logic [NM*4-1:0]   axis_in_tid = '0;
  logic [NM*4-1:0]   axis_in_tdest = '0;
  logic [NM*KW-1:0]  axis_in_tkeep = '0;
  logic [NM-1:0]     axis_in_tlast = '0;
  logic [NM-1:0]     axis_in_tvalid = '0;
  logic [NM-1:0]     axis_in_tready;
  logic [DW-1:0]     axis_out_tdata;
  logic [3:0]        axis_out_tid;
  logic [3:0]        axis_out_tdest;
  logic [KW-1:0]     axis_out_tkeep;
  logic              axis_out_tlast;
  logic              axis_out_tvalid;
  logic              axis_out_tready = 1'b1;
  logic [1:0]        axis_out_tsrc;
  logic [NM-1:0]     master_enable = '1;
  logic              stall_error_irq;
  logic [1:0]        stall_error_src;
  logic              stall_error_clear = 1'b0;

  always #5 aclk = ~aclk;

  axis_tx_rr_arbiter #(
    .NUM_MASTERS(NM), .AXIS_BUS_WIDTH(DW), .AXIS_ID_WIDTH(4),
    .AXIS_DEST_WIDTH(4), .STALL_TIMEOUT_CYCLES(LIMIT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(axis_in_tdata), .axis_in_tid(axis_in_tid),
    .axis_in_tdest(axis_in_tdest), .axis_in_tkeep(axis_in_tkeep),
    .axis_in_tlast(axis_in_tlast), .axis_in_tvalid(axis_in_tvalid),
    .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tid(axis_out_tid),
    .axis_out_tdest(axis_out_tdest), .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tlast(axis_out_tlast), .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready), .axis_out_tsrc(axis_out_tsrc),
    .master_enable(master_enable), .stall_error_irq(stall_error_irq),
    .stall_error_src(stall_error_src), .stall_error_clear(stall_error_clear)
  );

  beat_t       q [NM][$];
  beat_t       obs[$];
  int          obs_cyc[$];
  beat_t       exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          tready_mode = 0;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  int          model_last = NM - 1;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int i = 0; i < NM; i++) if (q[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic push_beats(input int m, input int len, input bit term);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.tid  = 4'($urandom);
      b.dest = 4'($urandom);
      b.keep = 8'($urandom);
      b.last = term && (k == len - 1);
      b.src  = 2'(m);
      q[m].push_back(b);
    end
  endtask

  // Drive sources from queue heads at negedge, sample at negedge+1, pop accepted beats at posedge.
  task automatic tick();
    bit    fire [NM];
    beat_t b;
    @(negedge aclk);
    for (int i = 0; i < NM; i++) begin
      if (q[i].size() > 0) begin
        axis_in_tvalid[i]            = 1'b1;
        axis_in_tdata[i*DW +: DW]    = q[i][0].data;
        axis_in_tid[i*4 +: 4]        = q[i][0].tid;
        axis_in_tdest[i*4 +: 4]      = q[i][0].dest;
        axis_in_tkeep[i*KW +: KW]    = q[i][0].keep;
        axis_in_tlast[i]             = q[i][0].last;
      end else begin
        axis_in_tvalid[i]            = 1'b0;
        axis_in_tdata[i*DW +: DW]    = '0;
        axis_in_tid[i*4 +: 4]        = '0;
        axis_in_tdest[i*4 +: 4]      = '0;
        axis_in_tkeep[i*KW +: KW]    = '0;
        axis_in_tlast[i]             = 1'b0;
      end
    end
    case (tready_mode)
      0:       axis_out_tready = 1'b1;
      1:       axis_out_tready = (cyc % 2 == 0);
      2:       axis_out_tready = 1'($urandom_range(0, 1));
      default: axis_out_tready = 1'b0;
    endcase
    #1;
    for (int i = 0; i < NM; i++) fire[i] = axis_in_tvalid[i] && axis_in_tready[i];
    if (prev_hold) chk("hold_stable", 128'({axis_out_tvalid, axis_out_tdata}), 128'({1'b1, prev_data}));
    if (axis_out_tvalid && axis_out_tready) begin
      b.data = axis_out_tdata;
      b.tid  = axis_out_tid;
      b.dest = axis_out_tdest;
      b.keep = axis_out_tkeep;
      b.last = axis_out_tlast;
      b.src  = axis_out_tsrc;
      obs.push_back(b);
      obs_cyc.push_back(cyc);
    end
    prev_hold = axis_out_tvalid && !axis_out_tready;
    prev_data = axis_out_tdata;
    @(posedge aclk);
    for (int i = 0; i < NM; i++) if (fire[i]) void'(q[i].pop_front());
    cyc++;
    #1;
  endtask

  // Packet-level round robin over whatever is queued, continuing from model_last.
  task automatic predict();
    beat_t lq [NM][$];
    beat_t b;
    int    pm;
    for (int i = 0; i < NM; i++) lq[i] = q[i];
    for (int guard = 0; guard < 64; guard++) begin
      pm = -1;
      for (int k = 1; k <= NM; k++)
        if (pm < 0 && lq[(model_last + k) % NM].size() > 0) pm = (model_last + k) % NM;
      if (pm < 0) break;
      while (lq[pm].size() > 0) begin
        b = lq[pm].pop_front();
        exp_q.push_back(b);
        if (b.last) break;
      end
      model_last = pm;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((any_pending() || axis_out_tvalid) && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 128'(n < 2000), 128'(1'b1));
  endtask

  task automatic check_obs(input string tag);
    chk({tag, "_nbeats"}, 128'(obs.size()), 128'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 128'(obs[i]), 128'(exp_q[i]));
    obs     = {};
    obs_cyc = {};
    exp_q   = {};
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NM; i++) q[i] = {};
    axis_in_tvalid = '0;
    obs = {};
    obs_cyc = {};
    exp_q = {};
    prev_hold = 1'b0;
    model_last = NM - 1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int n;
    beat_t cp[$];

    // Reset state
    do_reset();
    chk("rst_tvalid", 128'(axis_out_tvalid), 128'(1'b0));
    chk("rst_tready", 128'(axis_in_tready), 128'(4'b0000));
    chk("rst_irq", 128'(stall_error_irq), 128'(1'b0));
    chk("rst_err_src", 128'(stall_error_src), 128'(2'd0));
    chk("rst_tsrc", 128'(axis_out_tsrc), 128'(2'd0));

    // Masters 0 and 2, 3-beat packets, back-to-back with one idle gap
    push_beats(0, 3, 1'b1);
    push_beats(2, 3, 1'b1);
    predict();
    drain("two_pkt");
    if (obs_cyc.size() == 6) begin
      chk("two_pkt_span", 128'(obs_cyc[5] - obs_cyc[0]), 128'(6));
      chk("two_pkt_gap", 128'(obs_cyc[3] - obs_cyc[2]), 128'(2));
      chk("two_pkt_inpkt", 128'(obs_cyc[2] - obs_cyc[0]), 128'(2));
    end else chk("two_pkt_obs", 128'(obs_cyc.size()), 128'(6));
    check_obs("two_pkt");

    // All masters with continuous single-beat packets
    for (int r = 0; r < 3; r++) for (int i = 0; i < NM; i++) push_beats(i, 1, 1'b1);
    predict();
    drain("rr_all");
    for (int k = 1; k < obs.size(); k++)
      chk($sformatf("rr_rotate%0d", k), 128'(obs[k].src), 128'(2'((obs[0].src + k) % NM)));
    check_obs("rr_all");

    // Toggling downstream ready
    tready_mode = 1;
    push_beats(1, 4, 1'b1);
    predict();
    drain("toggle");
    check_obs("toggle");
    tready_mode = 0;

    // Stall watchdog on master 3 while master 0 waits
    push_beats(3, 2, 1'b0);
    cp = q[3];
    n = 0;
    while (q[3].size() > 0 && n < 20) begin tick(); n++; end
    chk("stall_start_timeout", 128'(n < 20), 128'(1'b1));
    push_beats(0, 2, 1'b1);
    repeat (LIMIT - 1) tick();
    chk("stall_irq_before", 128'(stall_error_irq), 128'(1'b0));
    tick();
    chk("stall_irq_set", 128'(stall_error_irq), 128'(1'b1));
    chk("stall_src", 128'(stall_error_src), 128'(2'd3));
    chk("stall_blocked_obs", 128'(obs.size()), 128'(2));
    chk("stall_blocked_q0", 128'(q[0].size()), 128'(2));
    push_beats(3, 2, 1'b1);
    exp_q = cp;
    foreach (q[3][k]) exp_q.push_back(q[3][k]);
    foreach (q[0][k]) exp_q.push_back(q[0][k]);
    drain("stall");
    model_last = 0;
    chk("stall_irq_sticky", 128'(stall_error_irq), 128'(1'b1));
    stall_error_clear = 1'b1;
    tick();
    stall_error_clear = 1'b0;
    chk("stall_irq_cleared", 128'(stall_error_irq), 128'(1'b0));
    check_obs("stall");

    // Enable masking: master 0 disabled, master 1 disabled mid-packet
    master_enable = 4'b1110;
    push_beats(0, 1, 1'b1);
    push_beats(1, 3, 1'b1);
    for (int k = 0; k < 3; k++) exp_q.push_back(q[1][k]);
    push_beats(1, 2, 1'b1);
    n = 0;
    while (q[1].size() > 4 && n < 20) begin tick(); n++; end
    chk("en_start_timeout", 128'(n < 20), 128'(1'b1));
    master_enable = 4'b1100;
    repeat (20) tick();
    chk("en_q0_untouched", 128'(q[0].size()), 128'(1));
    chk("en_q1_not_regranted", 128'(q[1].size()), 128'(2));
    check_obs("en_mask");
    model_last = 1;
    master_enable = 4'b1111;
    predict();
    drain("en_restore");
    check_obs("en_restore");

    // Reset in the middle of a packet
    push_beats(2, 6, 1'b1);
    push_beats(1, 3, 1'b1);
    n = 0;
    while (q[2].size() > 4 && n < 40) begin tick(); n++; end
    chk("midrst_start_timeout", 128'(n < 40), 128'(1'b1));
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 128'(axis_out_tvalid), 128'(1'b0));
    chk("midrst_tready", 128'(axis_in_tready), 128'(4'b0000));
    do_reset();
    push_beats(1, 1, 1'b1);
    push_beats(3, 2, 1'b1);
    push_beats(0, 1, 1'b1);
    predict();
    drain("post_rst");
    if (obs.size() > 0) chk("post_rst_first_src", 128'(obs[0].src), 128'(2'd0));
    check_obs("post_rst");

    // Randomized packets with random downstream backpressure
    tready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NM; i++) begin
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) push_beats(i, $urandom_range(1, 5), 1'b1);
      end
      push_beats(r % NM, 2, 1'b1);
      predict();
      drain($sformatf("rand%0d", r));
      check_obs($sformatf("rand%0d", r));
    end
    tready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
